// File: rtl/idma_2d_midend.sv
// 2D iDMA mid-end: splits one strided 2D descriptor into a sequence of 1D backend requests
// and folds the backend responses into a single 2D completion. Optional: IDMA_2D_ERR_ABORT_EN.
module idma_2d_midend #(
    parameter int unsigned AddrWidth  = 32,
    parameter int unsigned TFLenWidth = 32,
    parameter int unsigned RepWidth   = 16,
    parameter int unsigned AxiIdWidth = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // 2D descriptor
    input  logic                  nd_req_valid_i,
    output logic                  nd_req_ready_o,
    input  logic [TFLenWidth-1:0] nd_length_i,
    input  logic [AddrWidth-1:0]  nd_src_addr_i,
    input  logic [AddrWidth-1:0]  nd_dst_addr_i,
    input  logic [AddrWidth-1:0]  nd_src_stride_i,
    input  logic [AddrWidth-1:0]  nd_dst_stride_i,
    input  logic [RepWidth-1:0]   nd_reps_i,
    input  logic [AxiIdWidth-1:0] nd_axi_id_i,
    // 1D backend request
    output logic                  burst_req_valid_o,
    input  logic                  burst_req_ready_i,
    output logic [TFLenWidth-1:0] burst_length_o,
    output logic [AddrWidth-1:0]  burst_src_addr_o,
    output logic [AddrWidth-1:0]  burst_dst_addr_o,
    output logic [AxiIdWidth-1:0] burst_axi_id_o,
    output logic                  burst_last_o,
    // 1D backend response
    input  logic                  burst_rsp_valid_i,
    output logic                  burst_rsp_ready_o,
    input  logic                  burst_rsp_error_i,
    // 2D completion
    output logic                  nd_rsp_valid_o,
    input  logic                  nd_rsp_ready_i,
    output logic                  nd_rsp_error_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                state_q;
    logic [TFLenWidth-1:0] length_q;
    logic [AddrWidth-1:0]  cur_src_q;
    logic [AddrWidth-1:0]  cur_dst_q;
    logic [AddrWidth-1:0]  src_stride_q;
    logic [AddrWidth-1:0]  dst_stride_q;
    logic [AxiIdWidth-1:0] axi_id_q;
    logic [RepWidth-1:0]   remaining_q;
    logic [RepWidth:0]     outstanding_q;
    logic [RepWidth:0]     outstanding_d;
    logic                  err_q;

    logic req_hs;
    logic rsp_hs;
    logic rsp_dec;
    logic abort;

    assign req_hs  = burst_req_valid_o && burst_req_ready_i;
    assign rsp_hs  = burst_rsp_valid_i && burst_rsp_ready_o;
    // A response with nothing outstanding is illegal; never let the counter wrap on it.
    assign rsp_dec = rsp_hs && (outstanding_q != '0);

`ifdef IDMA_2D_ERR_ABORT_EN
    assign abort = rsp_hs && burst_rsp_error_i;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({req_hs, rsp_dec})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= StIdle;
            length_q      <= '0;
            cur_src_q     <= '0;
            cur_dst_q     <= '0;
            src_stride_q  <= '0;
            dst_stride_q  <= '0;
            axi_id_q      <= '0;
            remaining_q   <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
        end else begin
            outstanding_q <= outstanding_d;
            if (rsp_hs) begin
                err_q <= err_q | burst_rsp_error_i;
            end
            unique case (state_q)
                StIdle: begin
                    if (nd_req_valid_i) begin
                        length_q      <= nd_length_i;
                        cur_src_q     <= nd_src_addr_i;
                        cur_dst_q     <= nd_dst_addr_i;
                        src_stride_q  <= nd_src_stride_i;
                        dst_stride_q  <= nd_dst_stride_i;
                        axi_id_q      <= nd_axi_id_i;
                        // Zero repetitions still moves one row.
                        remaining_q   <= (nd_reps_i == '0) ? RepWidth'(1) : nd_reps_i;
                        outstanding_q <= '0;
                        err_q         <= 1'b0;
                        state_q       <= StIssue;
                    end
                end
                StIssue: begin
                    if (req_hs) begin
                        cur_src_q   <= cur_src_q + src_stride_q;
                        cur_dst_q   <= cur_dst_q + dst_stride_q;
                        remaining_q <= remaining_q - 1'b1;
                    end
                    if (abort || (req_hs && remaining_q == RepWidth'(1))) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (outstanding_d == '0) begin
                        state_q <= StResp;
                    end
                end
                StResp: begin
                    if (nd_rsp_ready_i) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign nd_req_ready_o    = (state_q == StIdle);
    assign burst_req_valid_o = (state_q == StIssue);
    assign burst_length_o    = length_q;
    assign burst_src_addr_o  = cur_src_q;
    assign burst_dst_addr_o  = cur_dst_q;
    assign burst_axi_id_o    = axi_id_q;
    assign burst_last_o      = (state_q == StIssue) && (remaining_q == RepWidth'(1));
    assign burst_rsp_ready_o = (state_q == StIssue) || (state_q == StWait);
    assign nd_rsp_valid_o    = (state_q == StResp);
    assign nd_rsp_error_o    = (state_q == StResp) && err_q;
    assign busy_o            = (state_q != StIdle);

`ifndef SYNTHESIS
    rsp_without_outstanding: assert property (
        @(posedge clk_i) disable iff (rst_i) rsp_hs |-> (outstanding_q != '0)
    );
`endif

endmodule

// File: tb/tb_idma_2d_midend.sv
// Bench for idma_2d_midend: descriptor table plus hand-written reset / held-response sequences,
// with a reactive backend model and an expected-burst scoreboard.
module tb_idma_2d_midend;

    localparam int AW = 32;
    localparam int LW = 32;
    localparam int RW = 16;
    localparam int IW = 1;

`ifdef IDMA_2D_ERR_ABORT_EN
    localparam int ErrIssued = 2;
`else
    localparam int ErrIssued = 4;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          nd_req_valid = 1'b0;
    logic          nd_req_ready;
    logic [LW-1:0] nd_length = '0;
    logic [AW-1:0] nd_src_addr = '0;
    logic [AW-1:0] nd_dst_addr = '0;
    logic [AW-1:0] nd_src_stride = '0;
    logic [AW-1:0] nd_dst_stride = '0;
    logic [RW-1:0] nd_reps = '0;
    logic [IW-1:0] nd_axi_id = '0;
    logic          burst_req_valid;
    logic          burst_req_ready = 1'b1;
    logic [LW-1:0] burst_length;
    logic [AW-1:0] burst_src_addr;
    logic [AW-1:0] burst_dst_addr;
    logic [IW-1:0] burst_axi_id;
    logic          burst_last;
    logic          burst_rsp_valid = 1'b0;
    logic          burst_rsp_ready;
    logic          burst_rsp_error = 1'b0;
    logic          nd_rsp_valid;
    logic          nd_rsp_ready = 1'b1;
    logic          nd_rsp_error;
    logic          busy;

    always #5 clk = ~clk;

    idma_2d_midend #(
        .AddrWidth (AW),
        .TFLenWidth(LW),
        .RepWidth  (RW),
        .AxiIdWidth(IW)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .nd_req_valid_i   (nd_req_valid),
        .nd_req_ready_o   (nd_req_ready),
        .nd_length_i      (nd_length),
        .nd_src_addr_i    (nd_src_addr),
        .nd_dst_addr_i    (nd_dst_addr),
        .nd_src_stride_i  (nd_src_stride),
        .nd_dst_stride_i  (nd_dst_stride),
        .nd_reps_i        (nd_reps),
        .nd_axi_id_i      (nd_axi_id),
        .burst_req_valid_o(burst_req_valid),
        .burst_req_ready_i(burst_req_ready),
        .burst_length_o   (burst_length),
        .burst_src_addr_o (burst_src_addr),
        .burst_dst_addr_o (burst_dst_addr),
        .burst_axi_id_o   (burst_axi_id),
        .burst_last_o     (burst_last),
        .burst_rsp_valid_i(burst_rsp_valid),
        .burst_rsp_ready_o(burst_rsp_ready),
        .burst_rsp_error_i(burst_rsp_error),
        .nd_rsp_valid_o   (nd_rsp_valid),
        .nd_rsp_ready_i   (nd_rsp_ready),
        .nd_rsp_error_o   (nd_rsp_error),
        .busy_o           (busy)
    );

    typedef struct {
        logic [LW-1:0] len;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [AW-1:0] sstr;
        logic [AW-1:0] dstr;
        logic [RW-1:0] reps;
        int            stall_at;
        int            err_at;
        int            rsp_lat;
        int            exp_n;
        bit            exp_err;
    } vec_t;

    typedef struct {
        logic [LW-1:0] len;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [IW-1:0] id;
        logic          last;
    } burst_t;

    typedef struct {
        int due;
        bit err;
    } rsp_t;

    int     n_tests = 0;
    int     n_fail = 0;
    burst_t exp_q[$];
    rsp_t   rsp_q[$];

    // Backend model knobs
    int cyc = 0;
    int req_cnt = 0;
    int stall_at = -1;
    int stall_left = 0;
    int err_at = -1;
    int rsp_lat = 2;
    bit held_v = 1'b0;
    burst_t held;
    burst_t e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Backend: decides ready/response at the falling edge for the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (burst_req_valid && held_v) begin
                chk("stall_stable_src", burst_src_addr, held.src);
                chk("stall_stable_dst", burst_dst_addr, held.dst);
                chk("stall_stable_last", burst_last, held.last);
            end
            burst_req_ready = !(burst_req_valid && req_cnt == stall_at && stall_left > 0);
            if (!burst_req_ready) stall_left--;
            held_v = burst_req_valid && !burst_req_ready;
            held = '{burst_length, burst_src_addr, burst_dst_addr, burst_axi_id, burst_last};
            if (burst_req_valid && burst_req_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("burst_len", burst_length, e.len);
                    chk("burst_src", burst_src_addr, e.src);
                    chk("burst_dst", burst_dst_addr, e.dst);
                    chk("burst_id", burst_axi_id, e.id);
                    chk("burst_last", burst_last, e.last);
                end
                rsp_q.push_back('{cyc + rsp_lat, req_cnt == err_at});
                req_cnt++;
            end
            if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                burst_rsp_valid = 1'b1;
                burst_rsp_error = rsp_q[0].err;
                if (burst_rsp_ready) void'(rsp_q.pop_front());
            end else begin
                burst_rsp_valid = 1'b0;
                burst_rsp_error = 1'b0;
            end
        end
    end

    task automatic setup(input vec_t v, input logic [IW-1:0] id);
        logic [AW-1:0] nreps;
        stall_at   = v.stall_at;
        stall_left = 5;
        err_at     = v.err_at;
        rsp_lat    = v.rsp_lat;
        req_cnt    = 0;
        held_v     = 1'b0;
        exp_q.delete();
        rsp_q.delete();
        nreps = (v.reps == '0) ? AW'(1) : AW'(v.reps);
        for (int i = 0; i < v.exp_n; i++) begin
            exp_q.push_back('{v.len, v.src + AW'(i) * v.sstr, v.dst + AW'(i) * v.dstr, id,
                              AW'(i) == nreps - 1});
        end
    endtask

    task automatic send_desc(input vec_t v, input logic [IW-1:0] id);
        @(negedge clk);
        nd_req_valid  = 1'b1;
        nd_length     = v.len;
        nd_src_addr   = v.src;
        nd_dst_addr   = v.dst;
        nd_src_stride = v.sstr;
        nd_dst_stride = v.dstr;
        nd_reps       = v.reps;
        nd_axi_id     = id;
        for (int k = 0; k < 50 && !nd_req_ready; k++) @(negedge clk);
        chk("desc_accept", nd_req_ready, 1);
        @(negedge clk);
        nd_req_valid = 1'b0;
    endtask

    task automatic wait_rsp_valid();
        for (int k = 0; k < 2000 && !nd_rsp_valid; k++) @(negedge clk);
        chk("rsp_valid", nd_rsp_valid, 1);
    endtask

    task automatic run_vec(input vec_t v, input logic [IW-1:0] id);
        setup(v, id);
        send_desc(v, id);
        wait_rsp_valid();
        chk("rsp_error", nd_rsp_error, v.exp_err);
        @(negedge clk);
        chk("issued_count", req_cnt, v.exp_n);
        chk("sb_drained", exp_q.size(), 0);
        chk("idle_busy", busy, 0);
        chk("idle_ready", nd_req_ready, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, nd_req_ready, 1);
        chk({tag, "_req_valid"}, burst_req_valid, 0);
        chk({tag, "_rsp_ready"}, burst_rsp_ready, 0);
        chk({tag, "_nd_rsp_valid"}, nd_rsp_valid, 0);
        chk({tag, "_nd_rsp_err"}, nd_rsp_error, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_last"}, burst_last, 0);
        chk({tag, "_src"}, burst_src_addr, 0);
        chk({tag, "_dst"}, burst_dst_addr, 0);
        chk({tag, "_len"}, burst_length, 0);
    endtask

    vec_t vecs[5];
    vec_t v;

    initial begin
        vecs[0] = '{32'd64, 32'h1000, 32'h8000, 32'h100, 32'h200, 16'd3, -1, -1, 2, 3, 1'b0};
        vecs[1] = '{32'd128, 32'h2000, 32'h4000, 32'h40, 32'h80, 16'd4, 1, -1, 2, 4, 1'b0};
        vecs[2] = '{32'd16, 32'h10, 32'h20, 32'hFFFF_FFF0, 32'h10, 16'd3, -1, -1, 2, 3, 1'b0};
        vecs[3] = '{32'd8, 32'h300, 32'h400, 32'h4, 32'h4, 16'd0, -1, -1, 2, 1, 1'b0};
        vecs[4] = '{32'd32, 32'h0, 32'h100, 32'h20, 32'h20, 16'd4, 2, 1, 1, ErrIssued, 1'b1};

        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        rst = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 5; t++) run_vec(vecs[t], IW'(t));

        // Reset while a request is held in ISSUE
        v = '{32'd48, 32'hA000, 32'hB000, 32'h10, 32'h10, 16'd5, 0, -1, 2, 0, 1'b0};
        setup(v, '0);
        stall_left = 1000;
        send_desc(v, 1'b1);
        repeat (2) @(negedge clk);
        chk("mid_req_valid", burst_req_valid, 1);
        chk("mid_busy", busy, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
        stall_left = 0;
        @(negedge clk);
        chk("rst_issued", req_cnt, 0);

        // Completion held in RESP while another descriptor is offered
        v = '{32'd4, 32'h40, 32'h80, 32'h4, 32'h8, 16'd2, -1, 0, 2, 2, 1'b1};
        setup(v, '0);
        nd_rsp_ready = 1'b0;
        send_desc(v, 1'b0);
        wait_rsp_valid();
        nd_req_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("hold_rsp_valid", nd_rsp_valid, 1);
            chk("hold_rsp_error", nd_rsp_error, 1);
            chk("hold_req_ready", nd_req_ready, 0);
        end
        nd_req_valid = 1'b0;
        nd_rsp_ready = 1'b1;
        @(negedge clk);
        chk("hold_done_busy", busy, 0);
        chk("hold_issued", req_cnt, 2);
        chk("hold_sb_drained", exp_q.size(), 0);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d",
                 n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
